bowl_frame_ctrl: RTL and testbench

//  Game sequencer for the pin_sensor datapath: arms a roll, waits out ball travel, waits for pin_state to settle,

---
 rtl/bowl_pkg.sv | 30 +++
 rtl/settle_detector.sv | 47 ++++
 rtl/bowl_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_bowl_frame_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bowl_pkg.sv
// Shared definitions for the bowling frame sequencer and its sensor helpers:
// FSM state encoding, the default pin count and a population-count helper.
package bowl_pkg;

    localparam int DEF_NUM_PINS = 3;

    // Fixed operand width of popcount(); callers zero-extend their pin vectors.
    localparam int POP_W = 32;

    // Frame sequencer states, kept as plain constants for legacy tooling.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_ROLLING = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_TALLY   = 3'd4;
    localparam logic [2:0] ST_RACK    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_FAULT   = 3'd7;

    // Number of set bits in v.
    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/settle_detector.sv
// Change-reset stability counter: settled goes high once din has held the
// same value for SETTLE_CYCLES consecutive enabled cycles. clear re-seeds
// the reference sample so the count always starts fresh.
module settle_detector
    import bowl_pkg::*;
#(
    parameter int W             = DEF_NUM_PINS,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         enable,
    input  logic         clear,
    output logic         settled
);

    localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);

    logic [W-1:0]  prev;
    logic [CW-1:0] cnt;

    // Track the previous sample and count unchanged cycles, saturating.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev <= '0;
            cnt  <= '0;
        end else if (clear) begin
            prev <= din;
            cnt  <= '0;
        end else if (enable) begin
            prev <= din;
            if (din != prev) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // The current unchanged cycle completes the required run.
    assign settled = enable && !clear && (din == prev) && (cnt >= CNT_LAST);

endmodule

// File: rtl/bowl_frame_ctrl.sv
// Game sequencer for the pin_sensor datapath: arms a roll, waits out ball
// travel, waits for the pins to settle, tallies knocked pins and runs the
// pin-rack reset handshake, for NUM_FRAMES frames of up to two rolls.
module bowl_frame_ctrl
    import bowl_pkg::*;
#(
    parameter int NUM_PINS      = DEF_NUM_PINS,
    parameter int NUM_FRAMES    = 10,
    parameter int ROLL_WINDOW   = 200_000_000,
    parameter int SETTLE_CYCLES = 50_000_000,
    parameter int RACK_TIMEOUT  = 300_000_000
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      roll_go,
    input  logic [NUM_PINS-1:0]                       pin_state,
    input  logic                                      rack_ack,
    output logic                                      rack_req,
    output logic [$clog2(NUM_FRAMES+1)-1:0]           frame_idx,
    output logic                                      roll_idx,
    output logic [$clog2(NUM_FRAMES*NUM_PINS+1)-1:0]  score,
    output logic [$clog2(NUM_PINS+1)-1:0]             last_knock,
    output logic                                      strike,
    output logic                                      spare,
    output logic                                      game_over,
    output logic                                      fault
);

    localparam int FW   = $clog2(NUM_FRAMES + 1);
    localparam int SW   = $clog2(NUM_FRAMES * NUM_PINS + 1);
    localparam int KW   = $clog2(NUM_PINS + 1);
    // One timer serves both ball travel and the rack timeout.
    localparam int TMAX = (ROLL_WINDOW > RACK_TIMEOUT) ? ROLL_WINDOW : RACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] ROLL_LAST = TW'(ROLL_WINDOW - 1);
    localparam logic [TW-1:0] RACK_LAST = TW'(RACK_TIMEOUT - 1);
    localparam logic [FW-1:0] LAST_FRM  = FW'(NUM_FRAMES);

    logic [2:0]          state;
    logic [TW-1:0]       tmr;
    logic [NUM_PINS-1:0] standing;
    logic [NUM_PINS-1:0] standing_nx;
    logic [POP_W-1:0]    knock_vec;
    logic [KW-1:0]       knock;
    logic                settled;

    settle_detector #(
        .W             (NUM_PINS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .din     (pin_state),
        .enable  (state == ST_SETTLE),
        .clear   (state != ST_SETTLE),
        .settled (settled)
    );

    // Pins that were standing and are now down; a pin that pops back up
    // only drops out of the mask, it never subtracts from the count.
    // NOTE: every variable gets its default first so no latch is inferred.
    always_comb begin
        knock_vec                 = '0;
        knock_vec[NUM_PINS-1:0]   = standing & ~pin_state;
        knock                     = KW'(popcount(knock_vec));
        standing_nx               = standing & pin_state;
    end

    // Frame sequencer and score datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            standing   <= '0;
            frame_idx  <= '0;
            roll_idx   <= 1'b0;
            score      <= '0;
            last_knock <= '0;
            strike     <= 1'b0;
            spare      <= 1'b0;
        end else begin
            strike <= 1'b0;
            spare  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_ARMED;
                        frame_idx  <= FW'(1);
                        roll_idx   <= 1'b0;
                        score      <= '0;
                        last_knock <= '0;
                        standing   <= pin_state;
                    end
                end
                ST_ARMED: begin
                    if (roll_go) begin
                        state <= ST_ROLLING;
                        tmr   <= '0;
                    end
                end
                ST_ROLLING: begin
                    if (tmr == ROLL_LAST) begin
                        state <= ST_SETTLE;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settled) begin
                        state <= ST_TALLY;
                    end
                end
                ST_TALLY: begin
                    score      <= score + SW'(knock);
                    last_knock <= knock;
                    standing   <= standing_nx;
                    tmr        <= '0;
                    if (standing_nx == '0) begin
                        strike <= ~roll_idx;
                        spare  <= roll_idx;
                        state  <= ST_RACK;
                    end else if (roll_idx) begin
                        state <= ST_RACK;
                    end else begin
                        roll_idx <= 1'b1;
                        state    <= ST_ARMED;
                    end
                end
                ST_RACK: begin
                    if (rack_ack) begin
                        roll_idx <= 1'b0;
                        if (frame_idx == LAST_FRM) begin
                            state <= ST_DONE;
                        end else begin
                            frame_idx <= frame_idx + FW'(1);
                            standing  <= '1;
                            state     <= ST_ARMED;
                        end
                    end else if (tmr == RACK_LAST) begin
                        state <= ST_FAULT;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                ST_FAULT: begin
                    // Held until reset.
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rack_req  = (state == ST_RACK);
    assign game_over = (state == ST_DONE);
    assign fault     = (state == ST_FAULT);

endmodule

// File: tb/tb_bowl_frame_ctrl.sv
// Directed bench for bowl_frame_ctrl with short timing parameters.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, so a roll_go sampled at edge Er shows its
// tally results after edge Er+13 (8 travel, 4 settle, 1 tally cycle).
module tb_bowl_frame_ctrl;

    localparam int NP = 3;
    localparam int NF = 2;
    localparam int RW = 8;
    localparam int SC = 4;
    localparam int RT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          roll_go;
    logic [NP-1:0] pin_state;
    logic          rack_ack;
    logic          rack_req;
    logic [1:0]    frame_idx;
    logic          roll_idx;
    logic [2:0]    score;
    logic [1:0]    last_knock;
    logic          strike;
    logic          spare;
    logic          game_over;
    logic          fault;

    int n_checks = 0;
    int n_fail   = 0;

    bowl_frame_ctrl #(
        .NUM_PINS      (NP),
        .NUM_FRAMES    (NF),
        .ROLL_WINDOW   (RW),
        .SETTLE_CYCLES (SC),
        .RACK_TIMEOUT  (RT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .roll_go    (roll_go),
        .pin_state  (pin_state),
        .rack_ack   (rack_ack),
        .rack_req   (rack_req),
        .frame_idx  (frame_idx),
        .roll_idx   (roll_idx),
        .score      (score),
        .last_knock (last_knock),
        .strike     (strike),
        .spare      (spare),
        .game_over  (game_over),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every output packed together; all zero after reset.
    task automatic check_all_zero(input string tag);
        check(tag, 32'({rack_req, frame_idx, roll_idx, score, last_knock,
                        strike, spare, game_over, fault}), 32'd0);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " frame"}, 32'({frame_idx, roll_idx, score, game_over}), 32'b01_0_000_0);
    endtask

    // One roll with a fixed pin outcome; checks the tally and pulse timing.
    task automatic do_roll(input string tag, input logic [2:0] pins,
                           input int kn, input int sc, input int st, input int sp,
                           input int ri, input int rq);
        roll_go = 1'b1;
        step();                        // Er
        roll_go   = 1'b0;
        pin_state = pins;
        repeat (12) step();            // Er+12
        check({tag, " no early pulse"}, 32'({strike, spare}), 32'd0);
        step();                        // Er+13
        check({tag, " last_knock"}, 32'(last_knock), 32'(kn));
        check({tag, " score"},      32'(score),      32'(sc));
        check({tag, " strike"},     32'(strike),     32'(st));
        check({tag, " spare"},      32'(spare),      32'(sp));
        check({tag, " roll_idx"},   32'(roll_idx),   32'(ri));
        check({tag, " rack_req"},   32'(rack_req),   32'(rq));
        step();                        // Er+14
        check({tag, " pulse width"}, 32'({strike, spare}), 32'd0);
    endtask

    task automatic do_ack(input string tag, input int fr, input int go);
        rack_ack = 1'b1;
        step();
        rack_ack = 1'b0;
        check({tag, " rack_req"},  32'(rack_req),  32'd0);
        check({tag, " frame_idx"}, 32'(frame_idx), 32'(fr));
        check({tag, " roll_idx"},  32'(roll_idx),  32'd0);
        check({tag, " game_over"}, 32'(game_over), 32'(go));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        roll_go   = 1'b0;
        rack_ack  = 1'b0;
        pin_state = 3'b111;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b1;
        step();
        check_all_zero("idle after reset");

        // Game A: frame 1 strike, frame 2 spare (3 + 1 + 2 = 6).
        pin_state = 3'b111;
        do_start("A start");
        do_roll("A strike", 3'b000, 3, 3, 1, 0, 0, 1);
        check("A frame during rack", 32'(frame_idx), 32'd1);
        do_ack("A ack1", 2, 0);
        pin_state = 3'b111;
        do_roll("A f2r0", 3'b110, 1, 4, 0, 0, 1, 0);
        do_roll("A spare", 3'b000, 2, 6, 0, 1, 1, 1);
        do_ack("A ack2", 2, 1);
        check("A score held", 32'(score), 32'd6);
        roll_go = 1'b1;
        step();
        roll_go = 1'b0;
        repeat (15) step();
        check("A roll_go in DONE", 32'({game_over, rack_req, score}), 32'b1_0_110);

        // Game B: bounce on roll 0, pin re-standing on roll 1, then 0 + 2.
        pin_state = 3'b111;
        do_start("B start");
        roll_go = 1'b1;
        step();                        // Er
        roll_go   = 1'b0;
        pin_state = 3'b110;
        repeat (8) step();             // Er+8: now settling
        for (int i = 0; i < 6; i++) begin
            pin_state[0] = ~pin_state[0];
            repeat (3) step();
        end
        check("B bounce no tally", 32'({roll_idx, score}), 32'd0);
        repeat (2) step();
        check("B stable no early tally", 32'({roll_idx, score}), 32'd0);
        step();
        check("B bounce last_knock", 32'(last_knock), 32'd1);
        check("B bounce score", 32'({roll_idx, score}), 32'b1_001);
        do_roll("B restand", 3'b101, 1, 2, 0, 0, 1, 1);
        do_ack("B ack1", 2, 0);
        pin_state = 3'b111;
        do_roll("B gutter", 3'b111, 0, 2, 0, 0, 1, 0);
        do_roll("B f2r1", 3'b001, 2, 4, 0, 0, 1, 1);
        do_ack("B ack2", 2, 1);
        check("B final score", 32'(score), 32'd4);
        roll_go = 1'b1;
        step();
        roll_go = 1'b0;
        repeat (15) step();
        check("B roll_go in DONE", 32'({game_over, rack_req, score}), 32'b1_0_100);

        // Game C: rack never acknowledged.
        pin_state = 3'b111;
        do_start("C start");
        do_roll("C strike", 3'b000, 3, 3, 1, 0, 0, 1);
        repeat (14) step();            // Er+28
        check("C before timeout", 32'({rack_req, fault}), 32'b10);
        step();                        // Er+29
        check("C timeout", 32'({rack_req, fault}), 32'b01);
        pin_state = 3'b111;
        start     = 1'b1;
        rack_ack  = 1'b1;
        step();
        start    = 1'b0;
        rack_ack = 1'b0;
        step();
        check("C start ignored in FAULT", 32'({fault, frame_idx, score, game_over}), 32'b1_01_011_0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_all_zero("C reset from FAULT");

        // Reset while settling, then stray inputs in IDLE.
        pin_state = 3'b111;
        do_start("D start");
        roll_go = 1'b1;
        step();
        roll_go   = 1'b0;
        pin_state = 3'b000;
        repeat (9) step();             // Er+9: settling
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_all_zero("D reset mid-settle");
        rack_ack = 1'b1;
        roll_go  = 1'b1;
        repeat (3) step();
        rack_ack = 1'b0;
        roll_go  = 1'b0;
        repeat (20) step();
        check_all_zero("D stray inputs ignored");
        pin_state = 3'b111;
        do_start("D restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
